// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder: coordinate recovery, line/frame measurement, lock FSM.
// Optional per-frame pixel checksum enabled by VGA_DEC_CHECKSUM_EN.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vgaclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank_b,
`ifdef VGA_DEC_CHECKSUM_EN
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [15:0] frame_sum,
`endif
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        h_err,
    output logic        v_err,
    output logic        locked
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic       r_hs_q, r_hs_qq, r_vs_q, r_vs_qq, r_bl_q, r_bl_qq;
    logic [9:0] r_h_cnt, r_x_cnt, r_v_cnt, r_y_cnt;
    logic       r_line_act;
    state_t     r_state;
    logic [2:0] r_good_cnt;
    logic       r_frame_bad;

    logic        w_hs_edge, w_vs_edge, w_bl_fall;
    logic [10:0] w_h_len;
    logic        w_h_timeout, w_h_err_now, w_v_err_now;
    logic        w_line_act;
    logic [9:0]  w_v_next, w_y_next;
    logic [3:0]  w_good_next;
    logic        w_frame_ok;

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_hs_q  <= 1'b0;
            r_hs_qq <= 1'b0;
            r_vs_q  <= 1'b0;
            r_vs_qq <= 1'b0;
            r_bl_q  <= 1'b0;
            r_bl_qq <= 1'b0;
        end else begin
            r_hs_q  <= hsync;
            r_hs_qq <= r_hs_q;
            r_vs_q  <= vsync;
            r_vs_qq <= r_vs_q;
            r_bl_q  <= blank_b;
            r_bl_qq <= r_bl_q;
        end
    end

    assign w_hs_edge   = r_hs_qq & ~r_hs_q;
    assign w_vs_edge   = r_vs_qq & ~r_vs_q;
    assign w_bl_fall   = r_bl_qq & ~r_bl_q;
    assign w_h_len     = {1'b0, r_h_cnt} + 11'd1;
    assign w_h_timeout = ~w_hs_edge && (r_h_cnt == 10'd1022);
    assign w_h_err_now = (w_hs_edge && (w_h_len != 11'(H_TOTAL)))
                       | w_h_timeout
                       | (w_bl_fall && (r_x_cnt != 10'(H_ACTIVE)));

    // A line arriving on the same cycle as vsync is counted into the ending frame.
    assign w_line_act  = r_line_act | r_bl_q;
    assign w_v_next    = r_v_cnt + {9'd0, w_hs_edge};
    assign w_y_next    = r_y_cnt + {9'd0, w_hs_edge & w_line_act};
    assign w_v_err_now = w_vs_edge && ((w_v_next != 10'(V_TOTAL)) || (w_y_next != 10'(V_ACTIVE)));

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_h_cnt    <= 10'd0;
            r_x_cnt    <= 10'd0;
            r_v_cnt    <= 10'd0;
            r_y_cnt    <= 10'd0;
            r_line_act <= 1'b0;
        end else begin
            if (w_hs_edge) begin
                r_h_cnt    <= 10'd0;
                r_x_cnt    <= 10'd0;
                r_line_act <= 1'b0;
            end else begin
                if (r_h_cnt != 10'd1023) r_h_cnt <= r_h_cnt + 10'd1;
                if (r_bl_q) begin
                    r_x_cnt    <= r_x_cnt + 10'd1;
                    r_line_act <= 1'b1;
                end
            end
            r_v_cnt <= w_vs_edge ? 10'd0 : w_v_next;
            r_y_cnt <= w_vs_edge ? 10'd0 : w_y_next;
        end
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            x           <= 10'd0;
            y           <= 10'd0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            line_len    <= 10'd0;
            frame_lines <= 10'd0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
        end else begin
            x           <= r_x_cnt;
            y           <= r_y_cnt;
            pixel_valid <= r_bl_q;
            frame_start <= w_vs_edge;
            h_err       <= w_h_err_now;
            v_err       <= w_v_err_now;
            if (w_hs_edge) line_len <= w_h_len[10] ? 10'd1023 : w_h_len[9:0];
            if (w_vs_edge) frame_lines <= w_v_next;
        end
    end

    assign w_good_next = {1'b0, r_good_cnt} + 4'd1;
    assign w_frame_ok  = ~r_frame_bad & ~w_h_err_now & ~w_v_err_now;

    // MEASURE judges the frame on live error conditions so the vsync that opens
    // it is not blamed; LOCKED reacts to the registered pulses, dropping a cycle later.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_good_cnt  <= 3'd0;
            r_frame_bad <= 1'b0;
            locked      <= 1'b0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    locked <= 1'b0;
                    if (w_vs_edge) begin
                        r_state     <= ST_MEASURE;
                        r_good_cnt  <= 3'd0;
                        r_frame_bad <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (w_vs_edge) begin
                        r_frame_bad <= 1'b0;
                        if (w_frame_ok) begin
                            r_good_cnt <= w_good_next[2:0];
                            if (w_good_next >= 4'(LOCK_FRAMES)) begin
                                r_state <= ST_LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            r_good_cnt <= 3'd0;
                        end
                    end else if (w_h_err_now || w_v_err_now) begin
                        r_frame_bad <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (h_err || v_err) begin
                        r_state <= ST_SEARCH;
                        locked  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_SEARCH;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_DEC_CHECKSUM_EN
    logic [7:0]  r_r_q, r_g_q, r_b_q;
    logic [15:0] r_acc;
    logic [15:0] w_pix_sum;

    assign w_pix_sum = 16'(r_r_q) + 16'(r_g_q) + 16'(r_b_q);

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_r_q     <= 8'd0;
            r_g_q     <= 8'd0;
            r_b_q     <= 8'd0;
            r_acc     <= 16'd0;
            frame_sum <= 16'd0;
        end else begin
            r_r_q <= r;
            r_g_q <= g;
            r_b_q <= b;
            if (w_vs_edge) begin
                frame_sum <= r_acc;
                r_acc     <= 16'd0;
            end else if (r_bl_q) begin
                r_acc <= r_acc + w_pix_sum;
            end
        end
    end
`endif

endmodule
